usb_txn_ctrl: RTL and testbench

//  Host-side transaction sequencer for the USB serial chain.
//  - Transmit chain: bs_encoder -> crc -> bit_stuff -> nrzi -> dpdm.
//  - Receive chain: rc_dpdm -> decode_nrzi -> bitUnstuffer.
//  - Turns one OUT/IN request into the packets on the bus: token, data, then handshake.
//  - Handles NAK, timeout and corruption by retrying, and reports a final status.

---
 rtl/usb_pkg.sv | 32 +++
 rtl/usb_rsp_timer.sv | 29 ++
 rtl/usb_txn_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared packet-type encoding, PID bytes and transaction status codes for the USB host sequencer.
// No logic and no latency; pure type and constant definitions.
// Backpressure: not applicable.
package usb_pkg;

    typedef enum logic [1:0] {
        PKT_NONE   = 2'b00,
        PKT_TOKEN  = 2'b01,
        PKT_DATA   = 2'b10,
        PKT_HSHAKE = 2'b11
    } pkt_type_t;

    typedef enum logic [1:0] {
        TXN_OK        = 2'b00,
        TXN_STALL     = 2'b01,
        TXN_EXHAUSTED = 2'b10
    } txn_status_t;

    // Full PID bytes: check nibble in the upper half, {~pid, pid}.
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    function automatic logic is_data_pid(input logic [7:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_rsp_timer.sv
// Response timer: counts while enabled, saturates at TIMEOUT_CYC and flags timeout there.
// Latency: timeout is combinational from the count register, valid in the cycle the limit is held.
// Backpressure: none; clear has priority over counting.
module usb_rsp_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = en && (cnt == LIMIT);

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host transaction sequencer: token, data and handshake phases with NAK/timeout/corruption retry.
// Latency: sent_pkt or rx_valid produces the next encoder strobe or state change one cycle later.
// Backpressure: the bus side paces everything via sent_pkt/rx_valid; txn_req is ignored while busy.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txn_req,
    input  logic        txn_dir,
    input  logic [6:0]  txn_addr,
    input  logic [3:0]  txn_endp,
    input  logic [63:0] txn_wdata,
    output logic        txn_busy,
    output logic        txn_done,
    output txn_status_t txn_status,
    output logic [63:0] txn_rdata,
    output pkt_type_t   enc_pkt_type,
    output logic [18:0] enc_token,
    output logic [71:0] enc_data,
    output logic [7:0]  enc_hshake,
    input  logic        sent_pkt,
    output logic        receive_data,
    output logic        receive_hshake,
    output logic        abort,
    input  logic        rx_valid,
    input  logic [7:0]  rx_pid,
    input  logic [63:0] rx_payload,
    input  logic        rx_crc_ok,
    input  logic        EOP_error
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_TOK,
        S_WAIT_TOK,
        S_SEND_DAT,
        S_WAIT_DAT,
        S_WAIT_HS,
        S_WAIT_IND,
        S_SEND_ACK,
        S_WAIT_ACK,
        S_RETRY,
        S_DONE
    } state_t;

    state_t        state;
    logic          dir_q;
    logic [RW-1:0] retry;
    logic          tmr_en;
    logic          timeout;
    logic          rx_good;

    assign tmr_en  = (state == S_WAIT_HS) || (state == S_WAIT_IND);
    assign rx_good = rx_crc_ok && !EOP_error;

    usb_rsp_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!tmr_en),
        .en      (tmr_en),
        .timeout (timeout)
    );

    // Outputs are registered on the transition into the state they belong to,
    // so each strobe is high exactly for the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            dir_q          <= 1'b0;
            retry          <= '0;
            txn_busy       <= 1'b0;
            txn_done       <= 1'b0;
            txn_status     <= TXN_OK;
            txn_rdata      <= '0;
            enc_pkt_type   <= PKT_NONE;
            enc_token      <= '0;
            enc_data       <= '0;
            enc_hshake     <= '0;
            receive_data   <= 1'b0;
            receive_hshake <= 1'b0;
            abort          <= 1'b0;
        end else begin
            enc_pkt_type <= PKT_NONE;
            abort        <= 1'b0;
            txn_done     <= 1'b0;

            case (state)
                S_IDLE: begin
                    retry <= '0;
                    if (txn_req) begin
                        dir_q        <= txn_dir;
                        enc_token    <= {(txn_dir ? PID_IN : PID_OUT), txn_addr, txn_endp};
                        enc_data     <= {PID_DATA0, txn_wdata};
                        enc_hshake   <= PID_ACK;
                        txn_busy     <= 1'b1;
                        enc_pkt_type <= PKT_TOKEN;
                        state        <= S_SEND_TOK;
                    end
                end
                S_SEND_TOK: state <= S_WAIT_TOK;
                S_WAIT_TOK: begin
                    if (sent_pkt) begin
                        if (dir_q) begin
                            receive_data <= 1'b1;
                            state        <= S_WAIT_IND;
                        end else begin
                            enc_pkt_type <= PKT_DATA;
                            state        <= S_SEND_DAT;
                        end
                    end
                end
                S_SEND_DAT: state <= S_WAIT_DAT;
                S_WAIT_DAT: begin
                    if (sent_pkt) begin
                        receive_hshake <= 1'b1;
                        state          <= S_WAIT_HS;
                    end
                end
                S_WAIT_HS: begin
                    // A packet arriving in the timeout cycle takes priority.
                    if (rx_valid) begin
                        receive_hshake <= 1'b0;
                        if (rx_good && (rx_pid == PID_ACK || rx_pid == PID_STALL)) begin
                            txn_status <= (rx_pid == PID_ACK) ? TXN_OK : TXN_STALL;
                            txn_done   <= 1'b1;
                            txn_busy   <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            abort <= 1'b1;
                            state <= S_RETRY;
                        end
                    end else if (timeout) begin
                        receive_hshake <= 1'b0;
                        abort          <= 1'b1;
                        state          <= S_RETRY;
                    end
                end
                S_WAIT_IND: begin
                    if (rx_valid) begin
                        receive_data <= 1'b0;
                        if (rx_good && is_data_pid(rx_pid)) begin
                            txn_rdata    <= rx_payload;
                            enc_pkt_type <= PKT_HSHAKE;
                            state        <= S_SEND_ACK;
                        end else if (rx_good && rx_pid == PID_STALL) begin
                            txn_status <= TXN_STALL;
                            txn_done   <= 1'b1;
                            txn_busy   <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            abort <= 1'b1;
                            state <= S_RETRY;
                        end
                    end else if (timeout) begin
                        receive_data <= 1'b0;
                        abort        <= 1'b1;
                        state        <= S_RETRY;
                    end
                end
                S_SEND_ACK: state <= S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (sent_pkt) begin
                        txn_status <= TXN_OK;
                        txn_done   <= 1'b1;
                        txn_busy   <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_RETRY: begin
                    retry <= retry + 1'b1;
                    if (retry == RETRY_LAST) begin
                        txn_status <= TXN_EXHAUSTED;
                        txn_done   <= 1'b1;
                        txn_busy   <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        enc_pkt_type <= PKT_TOKEN;
                        state        <= S_SEND_TOK;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl acting as the bus and device side of the serial chain.
// Expected encoder strobes, aborts and completions are queued as stimulus is driven and checked on output.
// Waits on the DUT are cycle-bounded so the run always reaches its summary.
module tb_usb_txn_ctrl;
    import usb_pkg::*;

    localparam int TMO = 255;
    localparam int K_TOK = 1, K_DAT = 2, K_HS = 3, K_ABORT = 4, K_DONE = 5, K_NONE = 15;

    typedef struct {
        int          kind;
        logic [71:0] val;
        logic        chk_rd;
        logic [63:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txn_req = 1'b0;
    logic        txn_dir = 1'b0;
    logic [6:0]  txn_addr = '0;
    logic [3:0]  txn_endp = '0;
    logic [63:0] txn_wdata = '0;
    logic        txn_busy, txn_done;
    txn_status_t txn_status;
    logic [63:0] txn_rdata;
    pkt_type_t   enc_pkt_type;
    logic [18:0] enc_token;
    logic [71:0] enc_data;
    logic [7:0]  enc_hshake;
    logic        sent_pkt = 1'b0;
    logic        receive_data, receive_hshake, abort;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_pid = '0;
    logic [63:0] rx_payload = '0;
    logic        rx_crc_ok = 1'b0;
    logic        EOP_error = 1'b0;

    int   passed = 0;
    int   total = 0;
    int   tok_cnt = 0;
    int   abort_cnt = 0;
    exp_t sb[$];

    usb_txn_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRY(8)) dut (
        .clk(clk), .rst(rst), .txn_req(txn_req), .txn_dir(txn_dir), .txn_addr(txn_addr),
        .txn_endp(txn_endp), .txn_wdata(txn_wdata), .txn_busy(txn_busy), .txn_done(txn_done),
        .txn_status(txn_status), .txn_rdata(txn_rdata), .enc_pkt_type(enc_pkt_type),
        .enc_token(enc_token), .enc_data(enc_data), .enc_hshake(enc_hshake), .sent_pkt(sent_pkt),
        .receive_data(receive_data), .receive_hshake(receive_hshake), .abort(abort),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_payload(rx_payload), .rx_crc_ok(rx_crc_ok),
        .EOP_error(EOP_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int kind, input logic [71:0] val, input logic chk_rd, input logic [63:0] rd);
        exp_t e;
        e.kind = kind; e.val = val; e.chk_rd = chk_rd; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input string tag, input int kind, input logic [71:0] val, input logic [63:0] rd);
        exp_t e;
        e.kind = K_NONE; e.val = '0; e.chk_rd = 1'b0; e.rd = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_kind"}, 72'(kind), 72'(e.kind));
        if (e.kind == kind) begin
            chk({tag, "_val"}, val, e.val);
            if (e.chk_rd) chk({tag, "_rdata"}, {8'h0, rd}, {8'h0, e.rd});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (enc_pkt_type == PKT_TOKEN) begin
                tok_cnt++;
                sb_pop("sb_token", K_TOK, {53'h0, enc_token}, '0);
            end else if (enc_pkt_type == PKT_DATA) begin
                sb_pop("sb_data", K_DAT, enc_data, '0);
            end else if (enc_pkt_type == PKT_HSHAKE) begin
                sb_pop("sb_hshake", K_HS, {64'h0, enc_hshake}, '0);
            end
            if (abort) begin
                abort_cnt++;
                sb_pop("sb_abort", K_ABORT, '0, '0);
            end
            if (txn_done) sb_pop("sb_done", K_DONE, {70'h0, txn_status}, txn_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sent();
        sent_pkt = 1'b1;
        tick();
        sent_pkt = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] pid, input logic [63:0] pay, input logic crc, input logic eop);
        rx_valid = 1'b1; rx_pid = pid; rx_payload = pay; rx_crc_ok = crc; EOP_error = eop;
        tick();
        rx_valid = 1'b0; EOP_error = 1'b0;
    endtask

    task automatic start(input logic dir, input logic [6:0] addr, input logic [3:0] endp, input logic [63:0] wd);
        txn_req = 1'b1; txn_dir = dir; txn_addr = addr; txn_endp = endp; txn_wdata = wd;
        tick();
        txn_req = 1'b0;
        chk("busy_rise", 72'(txn_busy), 72'(1));
    endtask

    // Wait for the next encoder strobe, then let the bus report the packet as sent.
    task automatic wait_strobe(input string tag, input pkt_type_t want);
        for (int i = 0; i < 400 && enc_pkt_type == PKT_NONE; i++) tick();
        chk(tag, 72'(enc_pkt_type), 72'(want));
        tick();
        pulse_sent();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && txn_done !== 1'b1; i++) tick();
        chk({tag, "_done"}, 72'(txn_done), 72'(1));
        chk({tag, "_busy"}, 72'(txn_busy), 72'(0));
        tick();
    endtask

    initial begin : stim
        logic [63:0] wd1, rd2, rd7;
        int n;
        wd1 = 64'h7ffe_0000_0000_0000;
        rd2 = 64'hDEAD_BEEF_0123_4567;
        rd7 = 64'h0123_4567_89AB_CDEF;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_outputs", {txn_busy, txn_done, txn_status, enc_pkt_type, receive_data, receive_hshake, abort},
            72'h0);
        chk("rst_enc", {enc_data[63:0], 8'h0} ^ {enc_token, 53'h0} ^ {enc_hshake, 64'h0}, 72'h0);

        // 1: OUT with ACK; a request while busy must be ignored
        push(K_TOK, {53'h0, 8'hE1, 7'h05, 4'h1}, 1'b0, '0);
        push(K_DAT, {8'hC3, wd1}, 1'b0, '0);
        push(K_DONE, 72'h0, 1'b0, '0);
        start(1'b0, 7'h05, 4'h1, wd1);
        wait_strobe("t1_token", PKT_TOKEN);
        chk("t1_latency_data", 72'(enc_pkt_type), 72'(PKT_DATA));
        wait_strobe("t1_data", PKT_DATA);
        chk("t1_arm_hs", 72'(receive_hshake), 72'(1));
        txn_req = 1'b1;
        tick();
        txn_req = 1'b0;
        tick();
        pulse_rx(PID_ACK, '0, 1'b1, 1'b0);
        wait_done("t1");
        chk("t1_disarm", 72'(receive_hshake), 72'(0));

        // 2: IN returning DATA1
        push(K_TOK, {53'h0, 8'h69, 7'h12, 4'h3}, 1'b0, '0);
        push(K_HS, 72'hD2, 1'b0, '0);
        push(K_DONE, 72'h0, 1'b1, rd2);
        start(1'b1, 7'h12, 4'h3, '0);
        wait_strobe("t2_token", PKT_TOKEN);
        chk("t2_arm_data", 72'(receive_data), 72'(1));
        repeat (3) tick();
        pulse_rx(PID_DATA1, rd2, 1'b1, 1'b0);
        wait_strobe("t2_ack", PKT_HSHAKE);
        wait_done("t2");

        // 3: OUT, NAK twice then ACK
        tok_cnt = 0; abort_cnt = 0;
        for (int a = 0; a < 3; a++) begin
            push(K_TOK, {53'h0, 8'hE1, 7'h33, 4'h7}, 1'b0, '0);
            push(K_DAT, {8'hC3, 64'h5555_AAAA_0000_FFFF}, 1'b0, '0);
            if (a < 2) push(K_ABORT, '0, 1'b0, '0);
        end
        push(K_DONE, 72'h0, 1'b0, '0);
        start(1'b0, 7'h33, 4'h7, 64'h5555_AAAA_0000_FFFF);
        for (int a = 0; a < 3; a++) begin
            wait_strobe("t3_token", PKT_TOKEN);
            wait_strobe("t3_data", PKT_DATA);
            tick();
            pulse_rx((a < 2) ? PID_NAK : PID_ACK, '0, 1'b1, 1'b0);
        end
        wait_done("t3");
        chk("t3_tokens", 72'(tok_cnt), 72'(3));
        chk("t3_aborts", 72'(abort_cnt), 72'(2));

        // 4: IN with no response at all
        abort_cnt = 0;
        for (int a = 0; a < 8; a++) begin
            push(K_TOK, {53'h0, 8'h69, 7'h01, 4'h2}, 1'b0, '0);
            push(K_ABORT, '0, 1'b0, '0);
        end
        push(K_DONE, 72'h2, 1'b0, '0);
        start(1'b1, 7'h01, 4'h2, '0);
        for (int a = 0; a < 8; a++) begin
            wait_strobe("t4_token", PKT_TOKEN);
            n = 1;
            while (abort !== 1'b1 && n < 1000) begin
                tick();
                n++;
            end
            chk("t4_abort_spacing", 72'(n), 72'(TMO + 2));
        end
        wait_done("t4");
        chk("t4_aborts", 72'(abort_cnt), 72'(8));

        // 5: IN, corrupted DATA0 then STALL; no ACK may go out
        push(K_TOK, {53'h0, 8'h69, 7'h7F, 4'hF}, 1'b0, '0);
        push(K_ABORT, '0, 1'b0, '0);
        push(K_TOK, {53'h0, 8'h69, 7'h7F, 4'hF}, 1'b0, '0);
        push(K_DONE, 72'h1, 1'b0, '0);
        start(1'b1, 7'h7F, 4'hF, '0);
        wait_strobe("t5_token", PKT_TOKEN);
        tick();
        pulse_rx(PID_DATA0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        wait_strobe("t5_token_retry", PKT_TOKEN);
        tick();
        pulse_rx(PID_STALL, '0, 1'b1, 1'b0);
        wait_done("t5");

        // 7: packet arrives in the very cycle the timer expires
        push(K_TOK, {53'h0, 8'h69, 7'h40, 4'h8}, 1'b0, '0);
        push(K_HS, 72'hD2, 1'b0, '0);
        push(K_DONE, 72'h0, 1'b1, rd7);
        start(1'b1, 7'h40, 4'h8, '0);
        wait_strobe("t7_token", PKT_TOKEN);
        repeat (TMO) tick();
        pulse_rx(PID_DATA0, rd7, 1'b1, 1'b0);
        wait_strobe("t7_ack", PKT_HSHAKE);
        wait_done("t7");

        // 6: reset while waiting for the handshake, then a fresh transaction
        push(K_TOK, {53'h0, 8'hE1, 7'h0A, 4'h4}, 1'b0, '0);
        push(K_DAT, {8'hC3, 64'hCAFE}, 1'b0, '0);
        start(1'b0, 7'h0A, 4'h4, 64'hCAFE);
        wait_strobe("t6_token", PKT_TOKEN);
        wait_strobe("t6_data", PKT_DATA);
        chk("t6_in_wait_hs", 72'(receive_hshake), 72'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_outputs", {txn_busy, txn_done, txn_status, enc_pkt_type, receive_data, receive_hshake, abort},
            72'h0);
        chk("t6_rst_data", {txn_rdata, enc_hshake} | enc_data | {53'h0, enc_token}, 72'h0);
        push(K_TOK, {53'h0, 8'hE1, 7'h0B, 4'h5}, 1'b0, '0);
        push(K_DAT, {8'hC3, 64'hBEEF}, 1'b0, '0);
        push(K_DONE, 72'h0, 1'b0, '0);
        start(1'b0, 7'h0B, 4'h5, 64'hBEEF);
        wait_strobe("t6_token2", PKT_TOKEN);
        wait_strobe("t6_data2", PKT_DATA);
        tick();
        pulse_rx(PID_ACK, '0, 1'b1, 1'b0);
        wait_done("t6");

        repeat (3) tick();
        chk("sb_drained", 72'(sb.size()), 72'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
